alu_issue_buffer: RTL and testbench

ALU_ISSUE_BUFFER -- requirements
Module: alu_issue_buffer

---
 rtl/alu_issue_pkg.sv | 16 +
 rtl/alu_issue_fifo.sv | 38 +++
 rtl/alu_issue_buffer.sv | 88 ++++++++
 tb/tb_alu_issue_buffer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared FSM state, MOVI encodings and buffered instruction layout.
package alu_issue_pkg;
  // Fields are sized for the widest supported configuration; modules narrow them.
  localparam int DW_MAX = 32;
  localparam int OPW_MAX = 16;
  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_ISSUE} state_e;
  typedef enum logic [1:0] {MOVI_REG, MOVI_MEM, MOVI_IMM, MOVI_RSV} movi_e;
  typedef struct packed {
    logic [OPW_MAX-1:0] op;
    movi_e              movi;
    logic [DW_MAX-1:0]  reg_a;
    logic [DW_MAX-1:0]  reg_b;
    logic [DW_MAX-1:0]  imm;
    logic [DW_MAX-1:0]  addr;
  } instr_t;
endpackage

// File: rtl/alu_issue_fifo.sv
// alu_issue_fifo: DEPTH-entry instruction store exposing the head entry and the MOVI of the entry behind it.
module alu_issue_fifo
  import alu_issue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  logic                         i_pop,
  input  instr_t                       i_wdata,
  output instr_t                       o_head,
  output movi_e                        o_next_movi,
  output logic [$clog2(DEPTH+1)-1:0]   o_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  instr_t r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr, w_rnext;
  logic [CW-1:0] r_cnt;
  assign w_rnext = r_rptr + AW'(1);
  assign o_head = r_mem[r_rptr];
  assign o_next_movi = r_mem[w_rnext].movi;
  assign o_cnt = r_cnt;
  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + AW'(1);
      if (i_pop) r_rptr <= w_rnext;
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  always_ff @(posedge i_clk)
    if (i_push) r_mem[r_wptr] <= i_wdata;
endmodule

// File: rtl/alu_issue_buffer.sv
// alu_issue_buffer: in-order instruction buffer that fetches memory operands and issues to the ALU.
module alu_issue_buffer
  import alu_issue_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int OP_WIDTH   = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         IN_VLD,
  output logic                         IN_RDY,
  input  logic [OP_WIDTH-1:0]          IN_OP,
  input  logic [1:0]                   IN_MOVI,
  input  logic [DATA_WIDTH-1:0]        IN_REG_A,
  input  logic [DATA_WIDTH-1:0]        IN_REG_B,
  input  logic [DATA_WIDTH-1:0]        IN_IMM,
  input  logic [DATA_WIDTH-1:0]        IN_MEM_ADDR,
  output logic                         MEM_REQ,
  output logic [DATA_WIDTH-1:0]        MEM_ADDR,
  input  logic                         MEM_ACK,
  input  logic [DATA_WIDTH-1:0]        MEM_DATA,
  output logic                         ACT,
  input  logic                         ALU_RDY,
  output logic [OP_WIDTH-1:0]          OP,
  output logic [1:0]                   MOVI,
  output logic [DATA_WIDTH-1:0]        REG_A,
  output logic [DATA_WIDTH-1:0]        REG_B,
  output logic [DATA_WIDTH-1:0]        MEM,
  output logic [DATA_WIDTH-1:0]        IMM,
  output logic [$clog2(DEPTH+1)-1:0]   CNT
);
  localparam int CW = $clog2(DEPTH+1);
  instr_t w_wdata, w_head;
  movi_e w_next_movi, w_nh_movi;
  state_e r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_opnd;
  logic [CW-1:0] w_cnt_nxt;
  logic w_push, w_pop, w_issue, w_fetch;
  assign w_wdata = '{op: OPW_MAX'(IN_OP), movi: movi_e'(IN_MOVI), reg_a: DW_MAX'(IN_REG_A),
                     reg_b: DW_MAX'(IN_REG_B), imm: DW_MAX'(IN_IMM), addr: DW_MAX'(IN_MEM_ADDR)};
  // Readiness depends only on registered occupancy, never on ALU_RDY.
  assign IN_RDY = CNT < CW'(DEPTH);
  assign w_issue = r_state == ST_ISSUE;
  assign w_fetch = r_state == ST_FETCH;
  assign w_push = IN_VLD & IN_RDY;
  assign w_pop = w_issue & ALU_RDY;
  assign w_cnt_nxt = CNT + CW'(w_push) - CW'(w_pop);
  // Head after a pop: the queued successor, or the same-edge push when the buffer held one entry.
  assign w_nh_movi = CNT > CW'(1) ? w_next_movi : movi_e'(IN_MOVI);
  alu_issue_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk       (CLK),
    .i_rst_n     (RST),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .i_wdata     (w_wdata),
    .o_head      (w_head),
    .o_next_movi (w_next_movi),
    .o_cnt       (CNT)
  );
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (CNT != '0) w_state_nxt = w_head.movi == MOVI_MEM ? ST_FETCH : ST_ISSUE;
      ST_FETCH: if (MEM_ACK) w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (ALU_RDY) w_state_nxt = w_cnt_nxt == '0 ? ST_IDLE :
                                           w_nh_movi == MOVI_MEM ? ST_FETCH : ST_ISSUE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      r_state <= ST_IDLE;
      r_opnd  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_fetch && MEM_ACK) r_opnd <= MEM_DATA;
    end
  assign MEM_REQ = w_fetch;
  assign MEM_ADDR = w_fetch ? DATA_WIDTH'(w_head.addr) : '0;
  assign ACT = w_issue;
  assign OP = w_issue ? OP_WIDTH'(w_head.op) : '0;
  assign MOVI = w_issue ? w_head.movi : 2'b00;
  assign REG_A = w_issue ? DATA_WIDTH'(w_head.reg_a) : '0;
  assign REG_B = w_issue ? DATA_WIDTH'(w_head.reg_b) : '0;
  assign IMM = w_issue ? DATA_WIDTH'(w_head.imm) : '0;
  assign MEM = (w_issue && w_head.movi == MOVI_MEM) ? r_opnd : '0;
endmodule

// File: tb/tb_alu_issue_buffer.sv
// tb_alu_issue_buffer: scoreboard bench with a cycle-rule reference model of issue order and timing.
module tb_alu_issue_buffer;
  logic CLK = 0, RST = 0, IN_VLD = 0, ALU_RDY = 0;
  logic IN_RDY, MEM_REQ, ACT;
  logic MEM_ACK = 0;
  logic [3:0] IN_OP = 0, OP;
  logic [1:0] IN_MOVI = 0, MOVI;
  logic [7:0] IN_REG_A = 0, IN_REG_B = 0, IN_IMM = 0, IN_MEM_ADDR = 0;
  logic [7:0] MEM_DATA = 0, MEM_ADDR, REG_A, REG_B, MEM, IMM;
  logic [2:0] CNT;
  alu_issue_buffer dut (
    .CLK(CLK), .RST(RST), .IN_VLD(IN_VLD), .IN_RDY(IN_RDY), .IN_OP(IN_OP), .IN_MOVI(IN_MOVI),
    .IN_REG_A(IN_REG_A), .IN_REG_B(IN_REG_B), .IN_IMM(IN_IMM), .IN_MEM_ADDR(IN_MEM_ADDR),
    .MEM_REQ(MEM_REQ), .MEM_ADDR(MEM_ADDR), .MEM_ACK(MEM_ACK), .MEM_DATA(MEM_DATA),
    .ACT(ACT), .ALU_RDY(ALU_RDY), .OP(OP), .MOVI(MOVI), .REG_A(REG_A), .REG_B(REG_B),
    .MEM(MEM), .IMM(IMM), .CNT(CNT)
  );
  always #5 CLK = ~CLK;
  typedef struct {
    logic [3:0] op;
    logic [1:0] movi;
    logic [7:0] a, b, imm, addr;
    int ready;
  } exp_t;
  exp_t exp_q[$];
  exp_t h, n;
  int pass = 0, total = 0, cyc = 0, mcnt = 0, ack_delay = 1, req_cycles = 0;
  bit late_ack = 0, drain_fail = 0, final_chk = 0, final_done = 0;
  function automatic logic [7:0] mem_of(input logic [7:0] a);
    return a ^ 8'h25;
  endfunction
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got === want) pass++;
    else $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, got, want);
  endtask
  // Memory responder: acknowledges after ack_delay cycles of continuous request.
  always @(posedge CLK) begin
    #1;
    req_cycles = MEM_REQ ? req_cycles + 1 : 0;
    MEM_ACK = (MEM_REQ && req_cycles >= ack_delay) || late_ack;
    MEM_DATA = mem_of(MEM_ADDR);
  end
  // Monitor: outputs reflect the state after edge cyc; inputs seen here apply at edge cyc+1.
  always @(negedge CLK) begin
    int pushed, popped;
    logic [1:0] e;
    cyc++;
    pushed = 0;
    popped = 0;
    if (!RST) begin
      chk("reset_outputs", 64'({ACT, MEM_REQ, MEM_ADDR, OP, MOVI, REG_A, REG_B, MEM, IMM, CNT, IN_RDY}), 64'h1);
      exp_q.delete();
      mcnt = 0;
    end else begin
      chk("cnt_rdy", 64'({CNT, IN_RDY}), 64'({3'(mcnt), mcnt < 4}));
      if (exp_q.size() == 0) chk("idle_outputs", 64'({ACT, MEM_REQ}), 64'h0);
      else begin
        h = exp_q[0];
        if (h.movi == 2'b01) e = cyc < h.ready ? 2'b00 : cyc < h.ready + ack_delay ? 2'b01 : 2'b10;
        else e = cyc >= h.ready ? 2'b10 : 2'b00;
        chk("act_req_timing", 64'({ACT, MEM_REQ}), 64'(e));
        if (e == 2'b01 && MEM_REQ) chk("mem_addr", 64'(MEM_ADDR), 64'(h.addr));
      end
      if (ACT && ALU_RDY && exp_q.size() > 0) begin
        h = exp_q.pop_front();
        chk("issue", 64'({OP, MOVI, REG_A, REG_B, IMM, MEM}),
            64'({h.op, h.movi, h.a, h.b, h.imm, h.movi == 2'b01 ? mem_of(h.addr) : 8'h00}));
        popped = 1;
        if (exp_q.size() > 0) exp_q[0].ready = cyc + 1;
      end
      if (IN_VLD && mcnt < 4) begin
        n = '{IN_OP, IN_MOVI, IN_REG_A, IN_REG_B, IN_IMM, IN_MEM_ADDR, 0};
        n.ready = exp_q.size() > 0 ? 0 : popped != 0 ? cyc + 1 : cyc + 2;
        exp_q.push_back(n);
        pushed = 1;
      end
      mcnt = mcnt + pushed - popped;
      if (final_chk && !final_done) begin
        chk("drained", 64'({exp_q.size() == 0, !drain_fail}), 64'h3);
        final_done = 1;
      end
    end
  end
  task automatic put(input logic [3:0] op, input logic [1:0] movi, input logic [7:0] a, b, imm, addr);
    IN_VLD = 1;
    IN_OP = op;
    IN_MOVI = movi;
    IN_REG_A = a;
    IN_REG_B = b;
    IN_IMM = imm;
    IN_MEM_ADDR = addr;
    @(posedge CLK);
    #1;
  endtask
  task automatic idle(input int k);
    IN_VLD = 0;
    repeat (k) begin
      @(posedge CLK);
      #1;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge CLK);
    #1;
    RST = 1;
    idle(2);
    ALU_RDY = 1;
    put(4'd3, 2'b00, 8'h12, 8'h34, 8'h00, 8'h00);
    idle(4);
    ack_delay = 3;
    put(4'd5, 2'b01, 8'h11, 8'h22, 8'h33, 8'h80);
    idle(8);
    ALU_RDY = 0;
    for (int i = 0; i < 5; i++) put(4'(i + 1), (i % 3 == 0) ? 2'b00 : (i % 3 == 1) ? 2'b10 : 2'b11,
                                    8'(16 * i), 8'(i + 7), 8'(i + 9), 8'(i + 3));
    idle(2);
    ALU_RDY = 1;
    idle(8);
    ALU_RDY = 0;
    put(4'd9, 2'b00, 8'hA1, 8'hB1, 8'hC1, 8'h01);
    put(4'd10, 2'b10, 8'hA2, 8'hB2, 8'hC2, 8'h02);
    idle(2);
    ALU_RDY = 1;
    put(4'd11, 2'b11, 8'hA3, 8'hB3, 8'hC3, 8'h03);
    idle(6);
    put(4'd7, 2'b01, 8'h01, 8'h02, 8'h03, 8'h44);
    idle(1);
    #3;
    RST = 0;
    @(posedge CLK);
    #1;
    RST = 1;
    late_ack = 1;
    idle(3);
    late_ack = 0;
    idle(2);
    ack_delay = int'($urandom_range(1, 3));
    for (int i = 0; i < 60; i++) begin
      IN_VLD = ($urandom % 4) != 0;
      IN_OP = 4'($urandom);
      IN_MOVI = 2'($urandom);
      IN_REG_A = 8'($urandom);
      IN_REG_B = 8'($urandom);
      IN_IMM = 8'($urandom);
      IN_MEM_ADDR = 8'($urandom);
      ALU_RDY = ($urandom % 4) != 0;
      @(posedge CLK);
      #1;
    end
    IN_VLD = 0;
    ALU_RDY = 1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge CLK);
    if (exp_q.size() != 0) drain_fail = 1;
    final_chk = 1;
    repeat (2) @(negedge CLK);
    #1;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
